// File: rtl/ripple_down_counter_pkg.sv
// Shared constants and types for the ripple down counter slice.
package ripple_down_counter_pkg;

  localparam int unsigned RIPPLE_DW_DEFAULT = 4;

  // Value the count wraps to after 0; valid for widths up to 32.
  function automatic logic [31:0] wrap_value(input int unsigned width);
    return (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
  endfunction

  typedef struct packed {
    logic underflow;
    logic wrapped;
  } status_t;

endpackage

// File: rtl/ripple_down_counter_if.sv
// Control and status bundle of the ripple down counter.
interface ripple_down_counter_if
  import ripple_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = RIPPLE_DW_DEFAULT
);
  logic             en;
  logic             clr_wrap;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             underflow;
  logic             wrapped;

  modport master (
    output en, clr_wrap,
    input  q, tc, underflow, wrapped
  );

  modport slave (
    input  en, clr_wrap,
    output q, tc, underflow, wrapped
  );
endinterface

// File: rtl/ripple_down_counter_t_stage.sv
// Single T flip-flop stage with asynchronous active-high reset.
module t_stage (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else if (t) q <= ~q;
  end
endmodule

// File: rtl/ripple_down_counter.sv
// Ripple binary down counter with terminal count, underflow pulse and sticky wrap.
// Define RIPPLE_DOWN_SYNC_EN to register q/tc (and delay status) for glitch-free outputs.
module ripple_down_counter
  import ripple_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = RIPPLE_DW_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  ripple_down_counter_if.slave bus
);

  logic [WIDTH-1:0] chain;
  logic             tc_raw;
  logic             wrap_now;
  status_t          status;

  t_stage u_stage0 (
    .clk   (clk),
    .reset (reset),
    .t     (bus.en),
    .q     (chain[0])
  );

  // Clocking each stage on the rising edge of the bit below yields a down count.
  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    t_stage u_stage (
      .clk   (chain[i-1]),
      .reset (reset),
      .t     (1'b1),
      .q     (chain[i])
    );
  end

  assign tc_raw   = (chain == '0);
  assign wrap_now = tc_raw & bus.en;

  // Sampled tc is the pre-edge value, so the pulse lands in the cycle after the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status <= '0;
    end else begin
      status.underflow <= wrap_now;
      if (wrap_now)
        status.wrapped <= 1'b1;
      else if (bus.clr_wrap)
        status.wrapped <= 1'b0;
    end
  end

`ifdef RIPPLE_DOWN_SYNC_EN
  logic [WIDTH:0] out_reg;
  status_t        status_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg  <= {1'b1, {WIDTH{1'b0}}};
      status_d <= '0;
    end else begin
      out_reg  <= {tc_raw, chain};
      status_d <= status;
    end
  end

  assign bus.q         = out_reg[WIDTH-1:0];
  assign bus.tc        = out_reg[WIDTH];
  assign bus.underflow = status_d.underflow;
  assign bus.wrapped   = status_d.wrapped;
`else
  assign bus.q         = chain;
  assign bus.tc        = tc_raw;
  assign bus.underflow = status.underflow;
  assign bus.wrapped   = status.wrapped;
`endif

endmodule
